// File: rtl/ysyx_23060221_pkg.sv
// Shared AXI constants and the icache controller state encoding.
package ysyx_23060221_pkg;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_AR,
    MISS_R,
    RESP
  } state_e;
endpackage

// File: rtl/ysyx_23060221_icache_array.sv
// Tag/valid/data storage for the direct-mapped icache. Only the valid bits are
// reset; fence (flush_i) clears every valid bit and wins over a same-cycle write.
module ysyx_23060221_icache_array #(
  parameter int NSETS      = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(NSETS),
  parameter int WORD_W     = $clog2(LINE_WORDS),
  parameter int TAG_W      = 30 - IDX_W - WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [WORD_W-1:0] rd_word_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [31:0]       rd_data_o,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_data_en_i,
  input  logic [WORD_W-1:0] wr_word_i,
  input  logic [31:0]       wr_data_i,
  input  logic              wr_tag_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              wr_valid_i
);
  logic [NSETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [31:0]      data_q [NSETS*LINE_WORDS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_tag_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_tag_en_i) tag_q[wr_idx_i] <= wr_tag_i;
    if (wr_data_en_i) data_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_word_i}];
endmodule

// File: rtl/ysyx_23060221_icache.sv
// Direct-mapped read-only icache: single-beat upstream fetches, whole-line INCR refills.
// Define ICACHE_PERF_EN to add the perf_hit/perf_miss lookup counters.
module ysyx_23060221_icache
  import ysyx_23060221_pkg::*;
#(
  parameter int          NSETS      = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] CMASK      = 32'h0000_0000,
  parameter logic [31:0] CMATCH     = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fence_i,
  output logic        in_arready,
  input  logic        in_arvalid,
  input  logic [31:0] in_araddr,
  input  logic [3:0]  in_arid,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  input  logic        in_rready,
  output logic        in_rvalid,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rlast,
  output logic [3:0]  in_rid,
  input  logic        out_arready,
  output logic        out_arvalid,
  output logic [31:0] out_araddr,
  output logic [3:0]  out_arid,
  output logic [7:0]  out_arlen,
  output logic [2:0]  out_arsize,
  output logic [1:0]  out_arburst,
  output logic        out_rready,
  input  logic        out_rvalid,
  input  logic [31:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic        out_rlast,
  input  logic [3:0]  out_rid
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);
  localparam int IDX_W  = $clog2(NSETS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = 30 - IDX_W - WORD_W;
  localparam logic [WORD_W:0] LAST_BEAT = (WORD_W+1)'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d, rdata_q, rdata_d;
  logic [3:0]        id_q, id_d;
  logic [WORD_W:0]   beat_q, beat_d;
  logic [1:0]        err_q, err_d;
  logic              fence_q, fence_d;

  logic [WORD_W-1:0] a_word;
  logic [IDX_W-1:0]  a_idx;
  logic [TAG_W-1:0]  a_tag, rd_tag;
  logic [31:0]       rd_data;
  logic              rd_valid, cacheable, lookup_hit;
  logic [WORD_W:0]   cap_beat, last_beat;
  logic              wr_data_en, wr_tag_en, wr_valid;
  logic              unused_inputs;

  assign a_word     = addr_q[2 +: WORD_W];
  assign a_idx      = addr_q[2 + WORD_W +: IDX_W];
  assign a_tag      = addr_q[31 -: TAG_W];
  assign cacheable  = (addr_q & CMASK) == CMATCH;
  assign lookup_hit = cacheable && rd_valid && (rd_tag == a_tag);
  // Non-cacheable fetches are a single beat carrying the requested word.
  assign cap_beat   = cacheable ? {1'b0, a_word} : '0;
  assign last_beat  = cacheable ? LAST_BEAT : '0;
  assign unused_inputs = ^{in_arlen, in_arsize, in_arburst, out_rid};

  ysyx_23060221_icache_array #(
    .NSETS      (NSETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (fence_i),
    .rd_idx_i     (a_idx),
    .rd_word_i    (a_word),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_data_o    (rd_data),
    .wr_idx_i     (a_idx),
    .wr_data_en_i (wr_data_en),
    .wr_word_i    (beat_q[WORD_W-1:0]),
    .wr_data_i    (out_rdata),
    .wr_tag_en_i  (wr_tag_en),
    .wr_tag_i     (a_tag),
    .wr_valid_i   (wr_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      err_q   <= RESP_OKAY;
      fence_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      fence_q <= fence_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a source keeps valid and payload stable until that edge.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    id_d        = id_q;
    beat_d      = beat_q;
    err_d       = err_q;
    fence_d     = fence_q;
    rdata_d     = rdata_q;
    wr_data_en  = 1'b0;
    wr_tag_en   = 1'b0;
    wr_valid    = 1'b0;
    in_arready  = 1'b0;
    in_rvalid   = 1'b0;
    in_rdata    = '0;
    in_rresp    = RESP_OKAY;
    in_rlast    = 1'b0;
    in_rid      = '0;
    out_arvalid = 1'b0;
    out_araddr  = '0;
    out_arid    = '0;
    out_arlen   = '0;
    out_arsize  = '0;
    out_arburst = '0;
    out_rready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_arready = 1'b1;
        if (in_arvalid) begin
          addr_d  = in_araddr;
          id_d    = in_arid;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        beat_d  = '0;
        err_d   = RESP_OKAY;
        fence_d = fence_i;
        if (lookup_hit) begin
          rdata_d = rd_data;
          state_d = RESP;
        end else begin
          state_d = MISS_AR;
        end
      end
      MISS_AR: begin
        fence_d     = fence_q | fence_i;
        out_arvalid = 1'b1;
        out_araddr  = cacheable ? {addr_q[31:2+WORD_W], {(2+WORD_W){1'b0}}} : addr_q;
        out_arlen   = cacheable ? 8'(LINE_WORDS - 1) : 8'd0;
        out_arsize  = 3'd2;
        out_arburst = BURST_INCR;
        out_arid    = id_q;
        if (out_arready) state_d = MISS_R;
      end
      MISS_R: begin
        fence_d    = fence_q | fence_i;
        out_rready = 1'b1;
        if (out_rvalid) begin
          wr_data_en = cacheable && (beat_q <= LAST_BEAT);
          if (beat_q == cap_beat) rdata_d = out_rdata;
          if (out_rresp != RESP_OKAY && err_q == RESP_OKAY) err_d = out_rresp;
          if (beat_q != '1) beat_d = beat_q + 1'b1;
          if (out_rlast) begin
            // A burst that ends early or late is reported as a slave error.
            if (beat_q != last_beat && err_d == RESP_OKAY) err_d = RESP_SLVERR;
            wr_tag_en = cacheable;
            wr_valid  = cacheable && (err_d == RESP_OKAY) && !fence_q && !fence_i;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        in_rvalid = 1'b1;
        in_rlast  = 1'b1;
        in_rdata  = rdata_q;
        in_rresp  = err_q;
        in_rid    = id_q;
        if (in_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (lookup_hit) perf_hit_q <= perf_hit_q + 32'd1;
      else            perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif
endmodule

// File: tb/tb_ysyx_23060221_icache.sv
// Bench for ysyx_23060221_icache: directed vector table, hand-written corner
// sequences, then random fetches checked against a line-level cache model.
module tb_ysyx_23060221_icache;
  localparam logic [31:0] CMASK  = 32'hF000_0000;
  localparam logic [31:0] CMATCH = 32'h3000_0000;

  logic        clock, reset, fence_i;
  logic        in_arready, in_arvalid;
  logic [31:0] in_araddr;
  logic [3:0]  in_arid;
  logic [7:0]  in_arlen;
  logic [2:0]  in_arsize;
  logic [1:0]  in_arburst;
  logic        in_rready, in_rvalid, in_rlast;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic [3:0]  in_rid;
  logic        out_arready, out_arvalid;
  logic [31:0] out_araddr;
  logic [3:0]  out_arid;
  logic [7:0]  out_arlen;
  logic [2:0]  out_arsize;
  logic [1:0]  out_arburst;
  logic        out_rready, out_rvalid, out_rlast;
  logic [31:0] out_rdata;
  logic [1:0]  out_rresp;
  logic [3:0]  out_rid;

  ysyx_23060221_icache #(
    .NSETS(16), .LINE_WORDS(4), .CMASK(CMASK), .CMATCH(CMATCH)
  ) dut (
    .clock(clock), .reset(reset), .fence_i(fence_i),
    .in_arready(in_arready), .in_arvalid(in_arvalid), .in_araddr(in_araddr),
    .in_arid(in_arid), .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .in_rready(in_rready), .in_rvalid(in_rvalid), .in_rdata(in_rdata),
    .in_rresp(in_rresp), .in_rlast(in_rlast), .in_rid(in_rid),
    .out_arready(out_arready), .out_arvalid(out_arvalid), .out_araddr(out_araddr),
    .out_arid(out_arid), .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_rready(out_rready), .out_rvalid(out_rvalid), .out_rdata(out_rdata),
    .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rid(out_rid)
  );

  // ---------------- clock / reset bookkeeping ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int reset_cnt = 0;
  always @(posedge reset) reset_cnt++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- downstream memory / slave ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_t;

  ar_t act_ar_q[$];
  ar_t exp_q[$];
  logic [31:0] mem_ovr [logic [31:0]];
  int  err_beat = -1;
  bit  rnd_tim  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    if (mem_ovr.exists(al)) return mem_ovr[al];
    return al ^ 32'h9E37_79B9 ^ {al[15:0], al[31:16]};
  endfunction

  initial begin : slave
    int  d, k, rc;
    ar_t ar;
    out_arready = 1'b0; out_rvalid = 1'b0; out_rdata = '0;
    out_rresp = 2'b00; out_rlast = 1'b0; out_rid = '0;
    forever begin
      @(negedge clock);
      if (reset || !out_arvalid) continue;
      d = rnd_tim ? int'($urandom_range(0, 3)) : 0;
      repeat (d) @(negedge clock);
      if (reset) continue;
      ar = '{out_araddr, out_arlen, out_arid};
      act_ar_q.push_back(ar);
      rc = reset_cnt;
      out_arready = 1'b1;
      @(negedge clock);
      out_arready = 1'b0;
      k = 0;
      while (k <= int'(ar.len) && rc == reset_cnt) begin
        if (rnd_tim && $urandom_range(0, 3) == 0) begin
          out_rvalid = 1'b0;
        end else begin
          out_rvalid = 1'b1;
          out_rdata  = mem_word(ar.addr + 32'(4 * k));
          out_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
          out_rlast  = (k == int'(ar.len));
          out_rid    = ar.id;
          if (out_rready) k++;
        end
        @(negedge clock);
      end
      out_rvalid = 1'b0; out_rlast = 1'b0; out_rresp = 2'b00;
    end
  end

  // ---------------- upstream driver ----------------
  task automatic fetch(input logic [31:0] addr, input logic [3:0] id, input int hold,
                       output logic [31:0] data, output logic [1:0] resp,
                       output logic [3:0] rid, output int lat);
    int n;
    @(negedge clock);
    in_arvalid = 1'b1; in_araddr = addr; in_arid = id;
    n = 0;
    while (!in_arready && n < 50) begin @(negedge clock); n++; end
    chk("arready", 32'(in_arready), 32'd1);
    @(negedge clock);
    in_arvalid = 1'b0;
    lat = 1;
    while (!in_rvalid && lat < 300) begin @(negedge clock); lat++; end
    chk("rvalid_seen", 32'(in_rvalid), 32'd1);
    data = in_rdata; resp = in_rresp; rid = in_rid;
    chk("rlast", 32'(in_rlast), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_rvalid", 32'(in_rvalid), 32'd1);
      chk("hold_rdata", in_rdata, data);
      chk("hold_rid", 32'(in_rid), 32'(rid));
    end
    in_rready = 1'b1;
    @(negedge clock);
    in_rready = 1'b0;
    chk("rvalid_drop", 32'(in_rvalid), 32'd0);
  endtask

  task automatic fence_idle();
    @(negedge clock); fence_i = 1'b1;
    @(negedge clock); fence_i = 1'b0;
  endtask

  task automatic fence_in_refill();
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!out_rready && n < 100);
    fence_i = 1'b1;
    @(negedge clock);
    fence_i = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  logic [3:0]  next_id = 4'd0;

  function automatic void model_flush();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endfunction

  // Predicts hit/miss, refill request, data and resp from the cache rules,
  // runs the fetch, compares, then updates the model's line state.
  task automatic model_fetch(input logic [31:0] addr, input bit fence_mid, input int eb, input int hold);
    bit          c, hit, fenced;
    int          idx;
    logic [1:0]  exp_resp, r;
    logic [31:0] d;
    logic [3:0]  rid, id;
    int          lat;
    ar_t         a, e;
    id     = next_id; next_id = next_id + 4'd1;
    c      = (addr & CMASK) == CMATCH;
    idx    = int'(addr[7:4]);
    hit    = c && mvalid[idx] && mtag[idx] == addr[31:8];
    fenced = fence_mid && c && !hit;
    exp_resp = (!hit && eb >= 0 && eb <= (c ? 3 : 0)) ? 2'b10 : 2'b00;
    if (!hit) exp_q.push_back('{c ? {addr[31:4], 4'h0} : addr, c ? 8'd3 : 8'd0, id});
    act_ar_q.delete();
    err_beat = hit ? -1 : eb;
    if (fenced) begin
      fork
        fetch(addr, id, hold, d, r, rid, lat);
        fence_in_refill();
      join
    end else begin
      fetch(addr, id, hold, d, r, rid, lat);
    end
    err_beat = -1;
    chk("rnd_data", d, mem_word(addr));
    chk("rnd_resp", 32'(r), 32'(exp_resp));
    chk("rnd_rid", 32'(rid), 32'(id));
    chk("rnd_ar_count", 32'(act_ar_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && act_ar_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_ar_q.pop_front();
      chk("rnd_araddr", a.addr, e.addr);
      chk("rnd_arlen", 32'(a.len), 32'(e.len));
      chk("rnd_arid", 32'(a.id), 32'(e.id));
    end
    exp_q.delete();
    if (fenced) model_flush();
    if (c && !hit) begin
      mvalid[idx] = (exp_resp == 2'b00) && !fenced;
      mtag[idx]   = addr[31:8];
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  rid;
    int          lat, n;
    ar_t         a;

    mem_ovr[32'h3000_0000] = 32'h11;
    mem_ovr[32'h3000_0004] = 32'h22;
    mem_ovr[32'h3000_0008] = 32'h33;
    mem_ovr[32'h3000_000C] = 32'h44;

    vecs[0] = '{32'h3000_0004, 32'h22, 1'b1, 32'h3000_0000, 8'd3, 7};
    vecs[1] = '{32'h3000_000C, 32'h44, 1'b0, 32'h0, 8'd0, 2};
    vecs[2] = '{32'h3000_0100, mem_word(32'h3000_0100), 1'b1, 32'h3000_0100, 8'd3, 7};
    vecs[3] = '{32'h3000_0004, 32'h22, 1'b1, 32'h3000_0000, 8'd3, 7};
    vecs[4] = '{32'h3000_0008, 32'h33, 1'b0, 32'h0, 8'd0, 2};
    vecs[5] = '{32'h2000_0008, mem_word(32'h2000_0008), 1'b1, 32'h2000_0008, 8'd0, 4};
    vecs[6] = '{32'h2000_0008, mem_word(32'h2000_0008), 1'b1, 32'h2000_0008, 8'd0, 4};

    reset = 1'b1; fence_i = 1'b0;
    in_arvalid = 1'b0; in_araddr = '0; in_arid = '0;
    in_arlen = 8'd0; in_arsize = 3'd2; in_arburst = 2'b01; in_rready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_arready", 32'(in_arready), 32'd1);
    chk("rst_rvalid", 32'(in_rvalid), 32'd0);
    chk("rst_arvalid", 32'(out_arvalid), 32'd0);
    chk("rst_rready", 32'(out_rready), 32'd0);
    chk("rst_araddr", out_araddr, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      act_ar_q.delete();
      fetch(vecs[i].addr, 4'(i + 1), 0, d, r, rid, lat);
      chk("vec_data", d, vecs[i].data);
      chk("vec_resp", 32'(r), 32'd0);
      chk("vec_rid", 32'(rid), 32'(i + 1));
      chk("vec_lat", 32'(lat), 32'(vecs[i].lat));
      chk("vec_ar_count", 32'(act_ar_q.size()), 32'(vecs[i].miss));
      if (vecs[i].miss && act_ar_q.size() > 0) begin
        a = act_ar_q.pop_front();
        chk("vec_araddr", a.addr, vecs[i].araddr);
        chk("vec_arlen", 32'(a.len), 32'(vecs[i].arlen));
        chk("vec_arid", 32'(a.id), 32'(i + 1));
      end
    end

    // Idle fence: next fetch misses; fence during refill: data returned, line stays invalid.
    fence_idle();
    act_ar_q.delete();
    fork
      fetch(32'h3000_0000, 4'd8, 0, d, r, rid, lat);
      fence_in_refill();
    join
    chk("fence_mid_data", d, 32'h11);
    chk("fence_mid_ar", 32'(act_ar_q.size()), 32'd1);
    act_ar_q.delete();
    fetch(32'h3000_0008, 4'd9, 0, d, r, rid, lat);
    chk("after_fence_data", d, 32'h33);
    chk("after_fence_ar", 32'(act_ar_q.size()), 32'd1);
    act_ar_q.delete();
    fetch(32'h3000_0004, 4'd10, 0, d, r, rid, lat);
    chk("refilled_hit_ar", 32'(act_ar_q.size()), 32'd0);
    chk("refilled_hit_lat", 32'(lat), 32'd2);

    // Fence landing in a LOOKUP hit: the hit still returns data, then the line is gone.
    act_ar_q.delete();
    fork
      fetch(32'h3000_000C, 4'd11, 0, d, r, rid, lat);
      begin @(negedge clock); @(negedge clock); fence_i = 1'b1; @(negedge clock); fence_i = 1'b0; end
    join
    chk("fence_hit_data", d, 32'h44);
    chk("fence_hit_ar", 32'(act_ar_q.size()), 32'd0);
    act_ar_q.delete();
    fetch(32'h3000_0004, 4'd12, 0, d, r, rid, lat);
    chk("fence_hit_refetch_ar", 32'(act_ar_q.size()), 32'd1);

    // Error beat 2: resp propagates, line not validated.
    err_beat = 2;
    act_ar_q.delete();
    fetch(32'h3000_0014, 4'd13, 0, d, r, rid, lat);
    err_beat = -1;
    chk("err_resp", 32'(r), 32'h2);
    chk("err_data", d, mem_word(32'h3000_0014));
    act_ar_q.delete();
    fetch(32'h3000_0014, 4'd14, 0, d, r, rid, lat);
    chk("err_refetch_ar", 32'(act_ar_q.size()), 32'd1);
    chk("err_refetch_resp", 32'(r), 32'd0);

    // Backpressure on a hit.
    act_ar_q.delete();
    fetch(32'h3000_0014, 4'd15, 5, d, r, rid, lat);
    chk("bp_data", d, mem_word(32'h3000_0014));
    chk("bp_rid", 32'(rid), 32'd15);
    chk("bp_ar", 32'(act_ar_q.size()), 32'd0);

    // Reset in the middle of a refill.
    @(negedge clock);
    in_arvalid = 1'b1; in_araddr = 32'h3000_0208; in_arid = 4'd3;
    @(negedge clock);
    in_arvalid = 1'b0;
    n = 0;
    while (!out_rready && n < 100) begin @(negedge clock); n++; end
    chk("reached_miss_r", 32'(out_rready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_arready", 32'(in_arready), 32'd1);
    chk("midrst_rready", 32'(out_rready), 32'd0);
    chk("midrst_rvalid", 32'(in_rvalid), 32'd0);
    repeat (3) @(negedge clock);
    model_flush();
    model_fetch(32'h3000_0014, 1'b0, -1, 0);
    model_fetch(32'h3000_0004, 1'b0, -1, 0);

    // Randomized fetches against the model.
    rnd_tim = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      logic [31:0] base;
      bit          c;
      int          eb;
      if ($urandom_range(0, 9) == 0) begin
        fence_idle();
        model_flush();
      end
      case ($urandom_range(0, 3))
        0: base = 32'h3000_0000;
        1: base = 32'h3000_0100;
        2: base = 32'h3000_0200;
        default: base = 32'h2000_0000;
      endcase
      addr = base | 32'($urandom_range(0, 63));
      c    = (addr & CMASK) == CMATCH;
      eb   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, c ? 3 : 0)) : -1;
      model_fetch(addr, ($urandom_range(0, 5) == 0), eb, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
